// File: rtl/ram_pkg.sv
// ram_pkg: shared state encodings, constants and byte-enable helper for the RAM arbiter
package ram_pkg;
  typedef enum logic {S_CPU, S_VID} st_e;
  localparam logic [3:0] BE_ALL = 4'hF;
  localparam int RAM_AW_DEF = 18;
  function automatic logic [3:0] onehot(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one SRAM port between the CPU and a read-only video DMA using wait-state slots
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int RAM_AW   = RAM_AW_DEF,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       cpu_adr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              cpu_ben,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              vid_req,
  input  logic [RAM_AW-1:0] vid_adr,
  output logic              vid_ack,
  output logic [31:0]       vid_data,
  output logic [RAM_AW-1:0] ram_adr,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYC);
  st_e         st_q, st_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        served_q, served_d, ack_q, ack_d;
  logic [31:0] vdata_q, vdata_d;
  logic        last, vid;
  logic        unused;
  assign unused = ^{cpu_rd, cpu_adr[23:RAM_AW+2]};
  always_comb begin
    last      = cnt_q == LAST_CNT;
    vid       = st_q == S_VID;
    ram_adr   = vid ? vid_adr : cpu_adr[RAM_AW+1:2];
    ram_wdata = cpu_wdata;
    ram_we    = ~vid & cpu_wr & last & ~rst;
    ram_oe    = ~ram_we;
    ram_be    = (vid | ~cpu_ben) ? BE_ALL : onehot(cpu_adr[1:0]);
    cpu_stall = vid | ~last;
    cpu_rdata = ram_rdata;
    vid_ack   = ack_q;
    vid_data  = vdata_q;
    cnt_d     = last ? 3'd0 : cnt_q + 3'd1;
    // served is consulted before it clears, forcing a CPU access between video slots
    st_d      = vid ? (last ? S_CPU : S_VID)
                    : ((last & vid_req & ~ack_q & ~served_q) ? S_VID : S_CPU);
    served_d  = last ? vid : served_q;
    ack_d     = vid & last;
    vdata_d   = (vid & last) ? ram_rdata : vdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_CPU;
      cnt_q    <= '0;
      served_q <= 1'b0;
      ack_q    <= 1'b0;
      vdata_q  <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
      ack_q    <= ack_d;
      vdata_q  <= vdata_d;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of three arbiter instances (WAIT_CYC = 0, 1, 2), each with its own SRAM model
module tb_ram_arbiter;
  logic        clk, rst;
  logic [23:0] cpu_adr [3];
  logic        cpu_rd [3], cpu_wr [3], cpu_ben [3], cpu_stall [3];
  logic [31:0] cpu_wdata [3], cpu_rdata [3];
  logic        vid_req [3], vid_ack [3];
  logic [17:0] vid_adr [3], ram_adr [3];
  logic [31:0] vid_data [3], ram_wdata [3], ram_rdata [3];
  logic        ram_oe [3], ram_we [3];
  logic [3:0]  ram_be [3];
  int n_chk = 0, n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : gi
    logic [31:0] mem [256];
    ram_arbiter #(.RAM_AW(18), .WAIT_CYC(g)) u (
      .clk(clk), .rst(rst),
      .cpu_adr(cpu_adr[g]), .cpu_rd(cpu_rd[g]), .cpu_wr(cpu_wr[g]), .cpu_ben(cpu_ben[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_stall(cpu_stall[g]),
      .vid_req(vid_req[g]), .vid_adr(vid_adr[g]), .vid_ack(vid_ack[g]), .vid_data(vid_data[g]),
      .ram_adr(ram_adr[g]), .ram_oe(ram_oe[g]), .ram_we(ram_we[g]), .ram_be(ram_be[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g])
    );
    always @(posedge clk) if (ram_we[g]) mem[ram_adr[g][7:0]] <= ram_wdata[g];
    assign ram_rdata[g] = mem[ram_adr[g][7:0]];
  end

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic align(input int i);
    for (int k = 0; k < 8 && cpu_stall[i]; k++) tick;
    @(negedge clk);
    chk("align_last", cpu_stall[i], 0);
    tick;
  endtask

  initial begin
    logic [7:0] exp_st, exp_ak;
    for (int i = 0; i < 3; i++) begin
      cpu_adr[i] = 0; cpu_rd[i] = 0; cpu_wr[i] = 0; cpu_ben[i] = 0; cpu_wdata[i] = 0;
      vid_req[i] = 0; vid_adr[i] = 0;
    end
    rst = 1;
    cpu_wr[0] = 1;
    tick; tick;
    @(negedge clk);
    chk("rst_stall0", cpu_stall[0], 0);
    chk("rst_stall1", cpu_stall[1], 1);
    chk("rst_stall2", cpu_stall[2], 1);
    chk("rst_we0", ram_we[0], 0);
    chk("rst_ack1", vid_ack[1], 0);
    chk("rst_vdata2", vid_data[2], 0);
    tick;
    rst = 0; cpu_wr[0] = 0;
    // word write then read, zero wait states
    cpu_adr[0] = 24'h000100; cpu_wr[0] = 1; cpu_wdata[0] = 32'h12345678;
    @(negedge clk);
    chk("t1_wr_adr", ram_adr[0], 18'h40);
    chk("t1_wr_we", ram_we[0], 1);
    chk("t1_wr_oe", ram_oe[0], 0);
    chk("t1_wr_be", ram_be[0], 4'hF);
    chk("t1_wr_stall", cpu_stall[0], 0);
    tick;
    cpu_wr[0] = 0; cpu_rd[0] = 1;
    @(negedge clk);
    chk("t1_rd_adr", ram_adr[0], 18'h40);
    chk("t1_rd_we", ram_we[0], 0);
    chk("t1_rd_data", cpu_rdata[0], 32'h12345678);
    chk("t1_rd_stall", cpu_stall[0], 0);
    tick;
    cpu_rd[0] = 0;
    // byte store with two wait states
    align(2);
    cpu_adr[2] = 24'h000203; cpu_ben[2] = 1; cpu_wr[2] = 1; cpu_wdata[2] = 32'hABABABAB;
    @(negedge clk);
    chk("t2_c1_stall", cpu_stall[2], 1);
    chk("t2_c1_we", ram_we[2], 0);
    chk("t2_c1_be", ram_be[2], 4'b1000);
    tick;
    @(negedge clk);
    chk("t2_c2_stall", cpu_stall[2], 1);
    chk("t2_c2_we", ram_we[2], 0);
    tick;
    @(negedge clk);
    chk("t2_c3_stall", cpu_stall[2], 0);
    chk("t2_c3_we", ram_we[2], 1);
    chk("t2_c3_be", ram_be[2], 4'b1000);
    tick;
    cpu_wr[2] = 0; cpu_ben[2] = 0;
    // single video read, zero wait states
    cpu_adr[0] = 24'h000040; cpu_wr[0] = 1; cpu_wdata[0] = 32'hCAFEF00D;
    tick;
    cpu_wr[0] = 0; cpu_adr[0] = 0;
    vid_req[0] = 1; vid_adr[0] = 18'h10;
    @(negedge clk);
    chk("t3_t_stall", cpu_stall[0], 0);
    tick;
    @(negedge clk);
    chk("t3_t1_stall", cpu_stall[0], 1);
    chk("t3_t1_adr", ram_adr[0], 18'h10);
    chk("t3_t1_ack", vid_ack[0], 0);
    tick;
    @(negedge clk);
    chk("t3_t2_ack", vid_ack[0], 1);
    chk("t3_t2_data", vid_data[0], 32'hCAFEF00D);
    chk("t3_t2_stall", cpu_stall[0], 0);
    vid_req[0] = 0;
    tick;
    @(negedge clk);
    chk("t3_t3_ack", vid_ack[0], 0);
    tick;
    // held request: ack cycle and the served flag each keep the CPU for a slot
    exp_st = 8'b1001_0010;
    exp_ak = 8'b0010_0100;
    vid_req[0] = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t4_stall_%0d", k), cpu_stall[0], exp_st[k]);
      chk($sformatf("t4_ack_%0d", k), vid_ack[0], exp_ak[k]);
      tick;
    end
    vid_req[0] = 0;
    tick; tick;
    // reset in the second cycle of a video slot, one wait state
    align(1);
    cpu_adr[1] = 24'h000080; cpu_wr[1] = 1; cpu_wdata[1] = 32'h5A5AA5A5;
    tick; tick;
    cpu_wr[1] = 0; cpu_adr[1] = 0;
    vid_req[1] = 1; vid_adr[1] = 18'h20;
    @(negedge clk);
    chk("t5_c0_stall", cpu_stall[1], 1);
    tick;
    @(negedge clk);
    chk("t5_c1_stall", cpu_stall[1], 0);
    tick;
    @(negedge clk);
    chk("t5_c2_adr", ram_adr[1], 18'h20);
    chk("t5_c2_stall", cpu_stall[1], 1);
    tick;
    rst = 1;
    @(negedge clk);
    chk("t5_rst_stall", cpu_stall[1], 1);
    chk("t5_rst_ack", vid_ack[1], 0);
    tick;
    rst = 0;
    @(negedge clk);
    chk("t5_post_stall", cpu_stall[1], 1);
    chk("t5_post_ack", vid_ack[1], 0);
    tick;
    @(negedge clk);
    chk("t5_c5_stall", cpu_stall[1], 0);
    tick;
    @(negedge clk);
    chk("t5_c6_ack", vid_ack[1], 0);
    tick;
    @(negedge clk);
    chk("t5_c7_ack", vid_ack[1], 0);
    tick;
    @(negedge clk);
    chk("t5_c8_ack", vid_ack[1], 1);
    chk("t5_c8_data", vid_data[1], 32'h5A5AA5A5);
    vid_req[1] = 0;
    tick;
    // store and video request on the same slot boundary
    cpu_adr[0] = 24'h000300; cpu_wr[0] = 1; cpu_wdata[0] = 32'hDEADBEEF;
    vid_req[0] = 1; vid_adr[0] = 18'hC0;
    @(negedge clk);
    chk("t6_we", ram_we[0], 1);
    chk("t6_stall", cpu_stall[0], 0);
    tick;
    cpu_wr[0] = 0;
    @(negedge clk);
    chk("t6_vid_we", ram_we[0], 0);
    chk("t6_vid_oe", ram_oe[0], 1);
    chk("t6_vid_adr", ram_adr[0], 18'hC0);
    tick;
    @(negedge clk);
    chk("t6_ack", vid_ack[0], 1);
    chk("t6_data", vid_data[0], 32'hDEADBEEF);
    vid_req[0] = 0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
